// File: rtl/mem_access_unit_if.sv
// Request/response and RAM port-A signal bundle for mem_access_unit.
// slave: the access unit; master: requester plus RAM side.
interface mem_access_unit_if #(
  parameter int unsigned widthad = 16
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [1:0]           req_size;
  logic                 req_signed;
  logic [31:0]          req_addr;
  logic [31:0]          req_wdata;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [31:0]          resp_rdata;
  logic                 resp_err;
  logic [widthad-1:0]   ram_address;
  logic                 ram_wren;
  logic [31:0]          ram_data;
  logic                 ram_rden;
  logic [31:0]          ram_q;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  resp_ready, ram_q,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output ram_address, ram_wren, ram_data, ram_rden
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output resp_ready, ram_q,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  ram_address, ram_wren, ram_data, ram_rden
  );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store front end for one block-RAM port; sub-word stores are read-modify-write.
// Optional MEM_MISALIGN_ERR_EN: flag misaligned/illegal requests instead of truncating the address.
module mem_access_unit #(
  parameter int unsigned widthad = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_access_unit_if.slave       bus
);
  localparam int unsigned AW = widthad;

  typedef enum logic [1:0] {IDLE, MERGE, RESP} state_t;

  state_t         r_state;
  logic [AW-1:0]  r_word_addr;
  logic [1:0]     r_addr_lo;
  logic [1:0]     r_size;
  logic           r_signed;
  logic           r_write;
  logic [31:0]    r_wdata;
  logic           r_resp_valid;
  logic [31:0]    r_resp_rdata;
  logic           r_resp_err;

  logic           w_idle;
  logic           w_err;
  logic [1:0]     w_lo;
  logic           w_direct_store;
  logic [7:0]     w_byte;
  logic [15:0]    w_half;
  logic [31:0]    w_load;
  logic [31:0]    w_merged;
  logic           w_unused_addr;

  assign w_idle        = (r_state == IDLE);
  assign w_unused_addr = ^bus.req_addr[31:AW+2];

`ifdef MEM_MISALIGN_ERR_EN
  assign w_err = ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                 ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'd0)) ||
                 (bus.req_size == 2'd3);
`else
  assign w_err = 1'b0;
`endif

  // Lane offset truncated to the access size; size 3 behaves as a word.
  always_comb begin
    case (bus.req_size)
      2'd0:    w_lo = bus.req_addr[1:0];
      2'd1:    w_lo = {bus.req_addr[1], 1'b0};
      default: w_lo = 2'd0;
    endcase
  end

  assign w_direct_store = bus.req_write && bus.req_size[1] && !w_err;

  // Lane extraction and store merge on the word read back during MERGE.
  always_comb begin
    case (r_addr_lo)
      2'd0:    w_byte = bus.ram_q[7:0];
      2'd1:    w_byte = bus.ram_q[15:8];
      2'd2:    w_byte = bus.ram_q[23:16];
      default: w_byte = bus.ram_q[31:24];
    endcase
    w_half = r_addr_lo[1] ? bus.ram_q[31:16] : bus.ram_q[15:0];
    case (r_size)
      2'd0:    w_load = r_signed ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
      2'd1:    w_load = r_signed ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
      default: w_load = bus.ram_q;
    endcase
    w_merged = bus.ram_q;
    case (r_size)
      2'd0: begin
        case (r_addr_lo)
          2'd0:    w_merged[7:0]   = r_wdata[7:0];
          2'd1:    w_merged[15:8]  = r_wdata[7:0];
          2'd2:    w_merged[23:16] = r_wdata[7:0];
          default: w_merged[31:24] = r_wdata[7:0];
        endcase
      end
      2'd1: begin
        if (r_addr_lo[1]) w_merged[31:16] = r_wdata[15:0];
        else              w_merged[15:0]  = r_wdata[15:0];
      end
      default: w_merged = r_wdata;
    endcase
  end

  // RAM port A: address passes straight through in IDLE, held from the register otherwise.
  assign bus.ram_address = w_idle ? bus.req_addr[AW+1:2] : r_word_addr;
  assign bus.ram_rden    = !rst && w_idle && bus.req_valid && !w_err;
  assign bus.ram_wren    = !rst && ((w_idle && bus.req_valid && w_direct_store) ||
                                    ((r_state == MERGE) && r_write));
  assign bus.ram_data    = w_idle ? bus.req_wdata : w_merged;

  assign bus.req_ready  = w_idle;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_word_addr  <= '0;
      r_addr_lo    <= 2'd0;
      r_size       <= 2'd0;
      r_signed     <= 1'b0;
      r_write      <= 1'b0;
      r_wdata      <= 32'd0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_word_addr <= bus.req_addr[AW+1:2];
            r_addr_lo   <= w_lo;
            r_size      <= bus.req_size;
            r_signed    <= bus.req_signed;
            r_write     <= bus.req_write;
            r_wdata     <= bus.req_wdata;
            if (w_err || w_direct_store) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= w_err;
              r_resp_rdata <= 32'd0;
            end else begin
              r_state <= MERGE;
            end
          end
        end
        MERGE: begin
          r_state      <= RESP;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= r_write ? 32'd0 : w_load;
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a port-A RAM model and an expected-response queue.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_access_unit_if #(.widthad(16)) bus ();

  mem_access_unit #(.widthad(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Port-A RAM model: read-during-write returns old data.
  logic [31:0] mem [0:65535];
  always @(posedge clk) begin
    if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_data;
    if (bus.ram_rden) bus.ram_q <= mem[bus.ram_address];
  end

  int wren_cnt = 0;
  int rden_cnt = 0;
  always @(posedge clk) begin
    if (bus.ram_wren) wren_cnt <= wren_cnt + 1;
    if (bus.ram_rden) rden_cnt <= rden_cnt + 1;
  end

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One request; hold > 0 keeps resp_ready low that many cycles once the response appears.
  task automatic req(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_d, input logic exp_e,
                     input int exp_wr, input int exp_rd, input int hold);
    int   wr0, rd0, t;
    exp_t e;
    sb.push_back('{d: exp_d, e: exp_e});
    @(negedge clk);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.resp_ready = (hold == 0);
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    wr0 = wren_cnt;
    rd0 = rden_cnt;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    t = 0;
    @(negedge clk);
    while (!bus.resp_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    e = sb.pop_front();
    if (!bus.resp_valid) begin
      chk({tag, "_timeout"}, 32'(bus.resp_valid), 32'd1);
    end else begin
      for (int i = 0; i < hold; i++) begin
        chk({tag, "_hold_valid"}, 32'(bus.resp_valid), 32'd1);
        chk({tag, "_hold_rdata"}, bus.resp_rdata, e.d);
        chk({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
        @(negedge clk);
      end
      bus.resp_ready = 1'b1;
      chk({tag, "_rdata"}, bus.resp_rdata, e.d);
      chk({tag, "_err"}, 32'(bus.resp_err), 32'(e.e));
      chk({tag, "_wren_cycles"}, 32'(wren_cnt - wr0), 32'(exp_wr));
      chk({tag, "_rden_cycles"}, 32'(rden_cnt - rd0), 32'(exp_rd));
      @(posedge clk);
      if (hold > 0) begin
        @(negedge clk);
        chk({tag, "_idle_after"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_valid_drop"}, 32'(bus.resp_valid), 32'd0);
      end
    end
  endtask

  int wr0;
  logic        mis_e;
  logic [31:0] mis_d, sz3_d;
  int          mis_rd;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_size   = 2'd2;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'h0;
    bus.resp_ready = 1'b1;

    // Reset with a pending request: no RAM strobes, responses idle.
    repeat (3) @(negedge clk);
    chk("rst_wren", 32'(bus.ram_wren), 32'd0);
    chk("rst_rden", 32'(bus.ram_rden), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    bus.req_valid = 1'b0;
    rst = 1'b0;

    req("st_word",   1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1, 1, 0);
    req("ld_word1",  1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 0, 1, 0);
    req("st_byte",   1'b1, 2'd0, 1'b0, 32'h12, 32'h55,       32'h0,        1'b0, 1, 1, 0);
    req("ld_word2",  1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDE55BEEF, 1'b0, 0, 1, 0);
    req("st_half",   1'b1, 2'd1, 1'b0, 32'h10, 32'h1234,     32'h0,        1'b0, 1, 1, 0);
    req("ld_word3",  1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDE551234, 1'b0, 0, 1, 0);
    req("ld_byte_s", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, 0, 1, 0);
    req("ld_byte_u", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'h000000DE, 1'b0, 0, 1, 0);
    req("ld_half_s", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        32'hFFFFDE55, 1'b0, 0, 1, 0);
    req("ld_half_u", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        32'h0000DE55, 1'b0, 0, 1, 0);
    req("ld_byte_0", 1'b0, 2'd0, 1'b1, 32'h10, 32'h0,        32'h00000034, 1'b0, 0, 1, 0);

`ifdef MEM_MISALIGN_ERR_EN
    mis_e = 1'b1; mis_d = 32'h0; sz3_d = 32'h0; mis_rd = 0;
`else
    mis_e = 1'b0; mis_d = 32'h00001234; sz3_d = 32'hDE551234; mis_rd = 1;
`endif
    req("ld_half_mis", 1'b0, 2'd1, 1'b0, 32'h11, 32'h0, mis_d, mis_e, 0, mis_rd, 0);
    req("ld_word_mis", 1'b0, 2'd2, 1'b0, 32'h12, 32'h0, sz3_d, mis_e, 0, mis_rd, 0);
    req("ld_size3",    1'b0, 2'd3, 1'b0, 32'h10, 32'h0, sz3_d, mis_e, 0, mis_rd, 0);
    // Address bits above the RAM width wrap.
    req("ld_wrap",     1'b0, 2'd2, 1'b0, 32'h0004_0010, 32'h0, 32'hDE551234, 1'b0, 0, 1, 0);

    req("ld_hold",   1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDE551234, 1'b0, 0, 1, 5);

    // Reset during the MERGE cycle of a byte store must abandon the write.
    @(negedge clk);
    chk("rm_req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_write = 1'b1; bus.req_size = 2'd0; bus.req_signed = 1'b0;
    bus.req_addr = 32'h10; bus.req_wdata = 32'hAA; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    wr0 = wren_cnt;
    #1 chk("rm_wren_in_merge", 32'(bus.ram_wren), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rm_wren_cycles", 32'(wren_cnt - wr0), 32'd0);
    chk("rm_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rm_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rm_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rm_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rm_wren", 32'(bus.ram_wren), 32'd0);
    rst = 1'b0;
    req("ld_after_rst", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDE551234, 1'b0, 0, 1, 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
